// File: rtl/cc_flag_unit.sv
// Execute-stage condition-code register and branch/cmov condition evaluation
// for the pipelined Y86-64 core.
module cc_flag_unit #(
    parameter int         WIDTH     = 64,
    parameter logic [3:0] OPQ_ICODE = 4'h6,
    parameter logic       RESET_ZF  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] e_alu_result,
    input  logic             e_alu_overflow,
    input  logic             e_bubble,
    input  logic             e_stall,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             e_cnd,
    output logic             cc_write
);

    localparam logic [1:0] STAT_AOK = 2'd0;

    function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                       input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return lt | zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return ~zf;
            4'd5:    return ~lt;
            4'd6:    return ~lt & ~zf;
            default: return 1'b0;
        endcase
    endfunction

    // A faulting older instruction in M or W blocks the update so flags never
    // reflect a younger OPq that will itself be squashed.
    assign cc_write = (e_icode == OPQ_ICODE) && !e_bubble && !e_stall &&
                      (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_zf <= RESET_ZF;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (cc_write) begin
            cc_zf <= (e_alu_result == '0);
            cc_sf <= e_alu_result[WIDTH-1];
            cc_of <= e_alu_overflow;
        end
    end

    // Uses only registered flags: no forwarding from the ALU of this cycle.
    assign e_cnd = cond_eval(e_ifun, cc_zf, cc_sf, cc_of);

endmodule

// File: tb/tb_cc_flag_unit.sv
// Scoreboard bench for cc_flag_unit: expected flag triples are queued as each
// Execute cycle is driven and compared after the following clock edge.
module tb_cc_flag_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] e_alu_result;
    logic        e_alu_overflow;
    logic        e_bubble;
    logic        e_stall;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic        cc_zf, cc_sf, cc_of, e_cnd, cc_write;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [2:0] sb[$];
    logic       m_zf, m_sf, m_of;
    logic       exp_wr;
    logic [2:0] exp3;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    cc_flag_unit #(.WIDTH(64), .OPQ_ICODE(4'h6), .RESET_ZF(1'b1)) dut (
        .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_alu_result(e_alu_result), .e_alu_overflow(e_alu_overflow),
        .e_bubble(e_bubble), .e_stall(e_stall), .m_stat(m_stat), .W_stat(W_stat),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .e_cnd(e_cnd), .cc_write(cc_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_cnd(input logic [3:0] f, input logic zf, input logic sf, input logic of);
        logic less;
        less = (sf != of);
        if (f == 4'd0) return 1'b1;
        if (f == 4'd1) return less || zf;
        if (f == 4'd2) return less;
        if (f == 4'd3) return zf;
        if (f == 4'd4) return !zf;
        if (f == 4'd5) return !less;
        if (f == 4'd6) return !less && !zf;
        return 1'b0;
    endfunction

    function automatic logic [2:0] pop_exp();
        if (sb.size() == 0) return 3'bxxx;
        return sb.pop_front();
    endfunction

    // Drive one Execute cycle and queue the flags expected after the next edge.
    task automatic apply(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] res,
                         input logic ovf, input logic bub, input logic stl,
                         input logic [1:0] ms, input logic [1:0] ws);
        e_icode = icode; e_ifun = ifun; e_alu_result = res; e_alu_overflow = ovf;
        e_bubble = bub; e_stall = stl; m_stat = ms; W_stat = ws;
        exp_wr = (icode == 4'h6) && !bub && !stl && (ms == 2'd0) && (ws == 2'd0);
        if (exp_wr) begin
            m_zf = (res == 64'd0);
            m_sf = res[63];
            m_of = ovf;
        end
        sb.push_back({m_zf, m_sf, m_of});
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cond(input logic [3:0] ifun);
        e_icode = 4'h7; e_ifun = ifun; e_bubble = 1'b0; e_stall = 1'b0;
        m_stat = 2'd0; W_stat = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        apply(4'h6, 4'h1, MIN64, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        exp3 = pop_exp();
        tot_cnt++;
        if ({cc_zf, cc_sf, cc_of} !== exp3) $display("FAIL preload_flags got %b exp %b", {cc_zf, cc_sf, cc_of}, exp3);
        else pass_cnt++;
        set_cond(4'h3);
        #2 rst = 1'b1;
        #1;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        tot_cnt++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL async_reset_flags got %b exp 100", {cc_zf, cc_sf, cc_of});
        else pass_cnt++;
        tot_cnt++;
        if (e_cnd !== 1'b1) $display("FAIL reset_je got %b exp 1", e_cnd);
        else pass_cnt++;
        set_cond(4'h4);
        tot_cnt++;
        if (e_cnd !== 1'b0) $display("FAIL reset_jne got %b exp 0", e_cnd);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals[2] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd3};
        logic        jl_exp[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            apply(4'h6, 4'h0, vals[i], 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
            tot_cnt++;
            if (cc_write !== 1'b1) $display("FAIL b2b_cc_write[%0d] got %b exp 1", i, cc_write);
            else pass_cnt++;
            tick();
            exp3 = pop_exp();
            tot_cnt++;
            if ({cc_zf, cc_sf, cc_of} !== exp3) $display("FAIL b2b_flags[%0d] got %b exp %b", i, {cc_zf, cc_sf, cc_of}, exp3);
            else pass_cnt++;
            set_cond(4'h2);
            tot_cnt++;
            if (e_cnd !== jl_exp[i]) $display("FAIL b2b_jl[%0d] got %b exp %b", i, e_cnd, jl_exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sub_zero();
        apply(4'h6, 4'h1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        exp3 = pop_exp();
        tot_cnt++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100 || exp3 !== 3'b100) $display("FAIL subzero_flags got %b exp 100", {cc_zf, cc_sf, cc_of});
        else pass_cnt++;
        set_cond(4'h1);
        tot_cnt++;
        if (e_cnd !== 1'b1) $display("FAIL subzero_jle got %b exp 1", e_cnd);
        else pass_cnt++;
        set_cond(4'h2);
        tot_cnt++;
        if (e_cnd !== 1'b0) $display("FAIL subzero_jl got %b exp 0", e_cnd);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        apply(4'h6, 4'h0, MIN64, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        exp3 = pop_exp();
        tot_cnt++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b011 || exp3 !== 3'b011) $display("FAIL ovf_flags got %b exp 011", {cc_zf, cc_sf, cc_of});
        else pass_cnt++;
        set_cond(4'h5);
        tot_cnt++;
        if (e_cnd !== 1'b1) $display("FAIL ovf_jge got %b exp 1", e_cnd);
        else pass_cnt++;
        set_cond(4'h6);
        tot_cnt++;
        if (e_cnd !== 1'b1) $display("FAIL ovf_jg got %b exp 1", e_cnd);
        else pass_cnt++;
        set_cond(4'h2);
        tot_cnt++;
        if (e_cnd !== 1'b0) $display("FAIL ovf_jl got %b exp 0", e_cnd);
        else pass_cnt++;
    endtask

    task automatic test_squash();
        logic [1:0] ms[4] = '{2'd2, 2'd0, 2'd0, 2'd0};
        logic [1:0] ws[4] = '{2'd0, 2'd3, 2'd0, 2'd0};
        logic       bb[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] ic[4] = '{4'h6, 4'h6, 4'h6, 4'h2};
        apply(4'h6, 4'h1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        void'(pop_exp());
        for (int i = 0; i < 4; i++) begin
            apply(ic[i], 4'h0, (i == 3) ? 64'hxxxx_xxxx_xxxx_xxxx : 64'd5, 1'b1, bb[i], 1'b0, ms[i], ws[i]);
            tot_cnt++;
            if (cc_write !== 1'b0) $display("FAIL squash_cc_write[%0d] got %b exp 0", i, cc_write);
            else pass_cnt++;
            tick();
            exp3 = pop_exp();
            tot_cnt++;
            if ({cc_zf, cc_sf, cc_of} !== exp3) $display("FAIL squash_flags[%0d] got %b exp %b", i, {cc_zf, cc_sf, cc_of}, exp3);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            apply(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, (i < 3), 2'd0, 2'd0);
            tot_cnt++;
            if (cc_write !== (i == 3)) $display("FAIL stall_cc_write[%0d] got %b exp %b", i, cc_write, (i == 3));
            else pass_cnt++;
            tick();
            exp3 = pop_exp();
            tot_cnt++;
            if ({cc_zf, cc_sf, cc_of} !== exp3) $display("FAIL stall_flags[%0d] got %b exp %b", i, {cc_zf, cc_sf, cc_of}, exp3);
            else pass_cnt++;
        end
    endtask

    task automatic test_cond_sweep();
        logic [63:0] res[6] = '{64'd0, 64'd0, 64'd9, 64'd9, MIN64, MIN64};
        logic        ovf[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply(4'h6, 4'h0, res[i], ovf[i], 1'b0, 1'b0, 2'd0, 2'd0);
            tick();
            exp3 = pop_exp();
            tot_cnt++;
            if ({cc_zf, cc_sf, cc_of} !== exp3) $display("FAIL sweep_flags[%0d] got %b exp %b", i, {cc_zf, cc_sf, cc_of}, exp3);
            else pass_cnt++;
            for (int f = 0; f < 16; f++) begin
                set_cond(f[3:0]);
                tot_cnt++;
                if (e_cnd !== ref_cnd(f[3:0], m_zf, m_sf, m_of))
                    $display("FAIL sweep_cnd[%0d] ifun %0d got %b exp %b", i, f, e_cnd, ref_cnd(f[3:0], m_zf, m_sf, m_of));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        e_icode = 4'h0; e_ifun = 4'h0; e_alu_result = 64'd0; e_alu_overflow = 1'b0;
        e_bubble = 1'b0; e_stall = 1'b0; m_stat = 2'd0; W_stat = 2'd0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        tick();
        tot_cnt++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL initial_reset got %b exp 100", {cc_zf, cc_sf, cc_of});
        else pass_cnt++;
        rst = 1'b0;
        test_reset();
        test_back_to_back();
        test_sub_zero();
        test_overflow();
        test_squash();
        test_stall();
        test_cond_sweep();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
